rf_exec_controller: RTL and testbench

Instruction sequencer that masters the 16x16-bit, two-read/one-write register file. It accepts 16-bit instructions over a valid/ready handshake and decodes them into register-file read addresses. It computes results with an internal 16-bit ALU and drives the single write port. It is the initiator end of the register-file interface and sits between instruction fetch and the register file in the six-instruction processor.

---
 rtl/rf_exec_controller.sv | 148 ++++++++++++++
 tb/tb_rf_exec_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rf_exec_controller.sv
// Four-phase instruction sequencer mastering a 16x16 two-read/one-write register file.
// Each instruction goes through IDLE -> READ -> EXEC -> WB. HALT stops the controller until Reset.
module rf_exec_controller #(
  parameter int DW        = 16,
  parameter int NREG_BITS = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InstrValid,
  input  logic [15:0]          Instr,
  output logic                 InstrReady,
  output logic [NREG_BITS-1:0] Aaddr,
  output logic [NREG_BITS-1:0] Baddr,
  input  logic [DW-1:0]        Adata,
  input  logic [DW-1:0]        Bdata,
  output logic [NREG_BITS-1:0] Waddr,
  output logic                 writeEn,
  output logic [DW-1:0]        WriteData,
  output logic                 Zero,
  output logic                 IllegalOp,
  output logic                 Halted,
  output logic [15:0]          InstrCount
);

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_LOADI = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MOV   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t         state_r;
  logic [15:0]    instr_r;
  logic [DW-1:0]  op_a_r;
  logic [DW-1:0]  op_b_r;
  logic [DW-1:0]  result_r;
  logic [DW-1:0]  alu_s;
  logic [3:0]     opcode_s;

  // Opcodes that update rd in write-back.
  function automatic logic writes_rd(input logic [3:0] op);
    logic w;
    case (op)
      OP_LOADI, OP_ADD, OP_SUB, OP_MOV: w = 1'b1;
      default:                          w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_HALT);
  endfunction

  assign opcode_s  = instr_r[15:12];
  assign Aaddr     = instr_r[11:8];
  assign Baddr     = instr_r[7:4];
  assign Waddr     = instr_r[3:0];
  assign WriteData = result_r;

  // ALU: result of the latched instruction from the latched operands.
  always_comb begin
    alu_s = {DW{1'b0}};
    case (opcode_s)
      OP_LOADI: alu_s = {{(DW-8){1'b0}}, instr_r[11:4]};
      OP_ADD:   alu_s = op_a_r + op_b_r;
      OP_SUB:   alu_s = op_a_r - op_b_r;
      OP_MOV:   alu_s = op_a_r;
      default:  alu_s = {DW{1'b0}};
    endcase
  end

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r    <= S_IDLE;
      instr_r    <= 16'h0000;
      op_a_r     <= {DW{1'b0}};
      op_b_r     <= {DW{1'b0}};
      result_r   <= {DW{1'b0}};
      Zero       <= 1'b0;
      IllegalOp  <= 1'b0;
      Halted     <= 1'b0;
      InstrCount <= 16'h0000;
      writeEn    <= 1'b0;
      InstrReady <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (InstrValid && InstrReady) begin
            instr_r    <= Instr;
            InstrReady <= 1'b0;
            if (Instr[15:12] == OP_HALT) begin
              state_r <= S_HALT;
              Halted  <= 1'b1;
            end else begin
              state_r   <= S_READ;
              IllegalOp <= is_illegal(Instr[15:12]);
            end
          end
        end
        S_READ: begin
          op_a_r    <= Adata;
          op_b_r    <= Bdata;
          IllegalOp <= 1'b0;
          state_r   <= S_EXEC;
        end
        S_EXEC: begin
          result_r <= alu_s;
          if ((opcode_s == OP_ADD) || (opcode_s == OP_SUB)) begin
            Zero <= (alu_s == {DW{1'b0}});
          end
          writeEn <= writes_rd(opcode_s);
          state_r <= S_WB;
        end
        S_WB: begin
          writeEn    <= 1'b0;
          InstrCount <= InstrCount + 16'd1;
          InstrReady <= 1'b1;
          state_r    <= S_IDLE;
        end
        S_HALT: begin
          InstrReady <= 1'b0;
          Halted     <= 1'b1;
          writeEn    <= 1'b0;
        end
        default: begin
          state_r    <= S_IDLE;
          writeEn    <= 1'b0;
          IllegalOp  <= 1'b0;
          InstrReady <= 1'b1;
        end
      endcase
    end
  end

  // NOOP shares the default ALU path; named here so the opcode map stays complete.
  logic unused_s;
  assign unused_s = (OP_NOOP == 4'd0);

endmodule

// File: tb/tb_rf_exec_controller.sv
// Directed bench for rf_exec_controller with a behavioural 16x16 register file.
// Expected values are hand-computed from the instruction sequence.
module tb_rf_exec_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [3:0]  Aaddr, Baddr, Waddr;
  logic [15:0] Adata, Bdata, WriteData;
  logic        writeEn, Zero, IllegalOp, Halted;
  logic [15:0] InstrCount;

  logic [15:0] rf [16];
  int          writes_n = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_prev = 0;
  int          checks = 0;
  int          errors = 0;

  rf_exec_controller #(.DW(16), .NREG_BITS(4)) dut (
    .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .Instr(Instr),
    .InstrReady(InstrReady), .Aaddr(Aaddr), .Baddr(Baddr),
    .Adata(Adata), .Bdata(Bdata), .Waddr(Waddr), .writeEn(writeEn),
    .WriteData(WriteData), .Zero(Zero), .IllegalOp(IllegalOp),
    .Halted(Halted), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) cyc <= cyc + 1;

  assign Adata = rf[Aaddr];
  assign Bdata = rf[Baddr];

  always @(posedge Clock) begin
    if (writeEn) begin
      rf[Waddr] <= WriteData;
      writes_n  <= writes_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and follow it through READ, EXEC and WB; returns at the WB negedge.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic we,
                           input logic [3:0] wa, input logic [15:0] wd, input logic ill);
    int n = 0;
    @(negedge Clock);
    while (!InstrReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, InstrReady}, 32'd1);
    chk({tag, "_ill_idle"}, {31'd0, IllegalOp}, 32'd0);
    InstrValid = 1'b1;
    Instr      = ins;
    @(posedge Clock);
    acc_prev = acc_cyc;
    acc_cyc  = cyc;
    #1 InstrValid = 1'b0;
    @(negedge Clock);
    chk({tag, "_read_ready"}, {31'd0, InstrReady}, 32'd0);
    chk({tag, "_read_ill"}, {31'd0, IllegalOp}, {31'd0, ill});
    chk({tag, "_read_we"}, {31'd0, writeEn}, 32'd0);
    @(negedge Clock);
    chk({tag, "_exec_ill"}, {31'd0, IllegalOp}, 32'd0);
    chk({tag, "_exec_we"}, {31'd0, writeEn}, 32'd0);
    @(negedge Clock);
    chk({tag, "_wb_we"}, {31'd0, writeEn}, {31'd0, we});
    if (we) begin
      chk({tag, "_wb_waddr"}, {28'd0, Waddr}, {28'd0, wa});
      chk({tag, "_wb_wdata"}, {16'd0, WriteData}, {16'd0, wd});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    Reset      = 1'b1;
    InstrValid = 1'b0;
    Instr      = 16'h0000;
    repeat (2) @(negedge Clock);
    chk("rst_ready", {31'd0, InstrReady}, 32'd1);
    chk("rst_halted", {31'd0, Halted}, 32'd0);
    chk("rst_count", {16'd0, InstrCount}, 32'd0);
    chk("rst_we", {31'd0, writeEn}, 32'd0);
    chk("rst_zero", {31'd0, Zero}, 32'd0);
    chk("rst_ill", {31'd0, IllegalOp}, 32'd0);
    Reset = 1'b0;

    run_instr("loadi1", 16'h1051, 1'b1, 4'd1, 16'h0005, 1'b0);
    run_instr("loadi2", 16'h1032, 1'b1, 4'd2, 16'h0003, 1'b0);
    chk("accept_gap", acc_cyc - acc_prev, 32'd4);
    @(negedge Clock);
    chk("count_2", {16'd0, InstrCount}, 32'd2);

    run_instr("add", 16'h2123, 1'b1, 4'd3, 16'h0008, 1'b0);
    chk("add_zero", {31'd0, Zero}, 32'd0);
    run_instr("sub_wrap", 16'h3214, 1'b1, 4'd4, 16'hFFFE, 1'b0);
    chk("sub_wrap_zero", {31'd0, Zero}, 32'd0);
    run_instr("sub_zero", 16'h3115, 1'b1, 4'd5, 16'h0000, 1'b0);
    chk("sub_zero_flag", {31'd0, Zero}, 32'd1);
    run_instr("mov", 16'h4306, 1'b1, 4'd6, 16'h0008, 1'b0);
    chk("mov_zero_hold", {31'd0, Zero}, 32'd1);
    run_instr("noop", 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0);
    run_instr("illegal", 16'hF123, 1'b0, 4'd0, 16'h0000, 1'b1);
    @(negedge Clock);
    chk("count_8", {16'd0, InstrCount}, 32'd8);
    chk("writes_6", writes_n, 32'd6);
    chk("r1", {16'd0, rf[1]}, 32'h0005);
    chk("r2", {16'd0, rf[2]}, 32'h0003);
    chk("r3", {16'd0, rf[3]}, 32'h0008);
    chk("r4", {16'd0, rf[4]}, 32'hFFFE);
    chk("r5", {16'd0, rf[5]}, 32'h0000);
    chk("r6", {16'd0, rf[6]}, 32'h0008);

    // HALT, then a held instruction that must never be consumed.
    InstrValid = 1'b1;
    Instr      = 16'h5000;
    @(posedge Clock);
    #1 Instr = 16'h1FF1;
    @(negedge Clock);
    chk("halt_halted", {31'd0, Halted}, 32'd1);
    chk("halt_ready", {31'd0, InstrReady}, 32'd0);
    repeat (6) @(negedge Clock);
    chk("halt_stays", {31'd0, Halted}, 32'd1);
    chk("halt_no_write", writes_n, 32'd6);
    chk("halt_count", {16'd0, InstrCount}, 32'd8);
    chk("halt_r15", {16'd0, rf[15]}, 32'h0000);
    InstrValid = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("unhalt_ready", {31'd0, InstrReady}, 32'd1);
    chk("unhalt_halted", {31'd0, Halted}, 32'd0);
    chk("unhalt_count", {16'd0, InstrCount}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Async reset during EXEC of ADD r7 <= r1 + r2.
    @(negedge Clock);
    InstrValid = 1'b1;
    Instr      = 16'h2127;
    @(posedge Clock);
    #1 InstrValid = 1'b0;
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, writeEn}, 32'd0);
    chk("mid_rst_ready", {31'd0, InstrReady}, 32'd1);
    chk("mid_rst_wdata", {16'd0, WriteData}, 32'd0);
    chk("mid_rst_zero", {31'd0, Zero}, 32'd0);
    chk("mid_rst_waddr", {28'd0, Waddr}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);
    chk("mid_rst_r7", {16'd0, rf[7]}, 32'h0000);
    chk("mid_rst_writes", writes_n, 32'd6);
    chk("mid_rst_count", {16'd0, InstrCount}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
